// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

    localparam int DEF_STARVE_LIMIT = 4;
    localparam int CNT_W            = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_prio_sel.sv
// Grant selection: data first, unless a pending fetch has waited out the starvation limit.
module arb_prio_sel
    import mem_port_arbiter_pkg::*;
(
    input  logic             i_if_req,
    input  logic             i_d_req,
    input  logic [CNT_W-1:0] i_starve_cnt,
    input  logic [CNT_W-1:0] i_limit,
    output gnt_t             o_gnt
);
    logic w_fetch_starved;

    assign w_fetch_starved = i_if_req && (i_starve_cnt == i_limit);

    always_comb begin
        o_gnt = GNT_NONE;
        if (i_d_req && !w_fetch_starved) begin
            o_gnt = GNT_D;
        end else if (i_if_req) begin
            o_gnt = GNT_I;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one single-ported memory, one transaction at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           r_state;
    state_t           w_state_nxt;
    gnt_t             w_gnt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             w_ack_i;
    logic             w_ack_d;

    logic             r_mem_req;
    logic             r_mem_we;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_wdata;
    logic [DW-1:0]    r_if_rdata;
    logic [DW-1:0]    r_d_rdata;
    logic             r_if_ready;
    logic             r_d_ready;

    arb_prio_sel u_sel (
        .i_if_req     (bus.if_req),
        .i_d_req      (bus.d_req),
        .i_starve_cnt (r_starve_cnt),
        .i_limit      (LIMIT),
        .o_gnt        (w_gnt)
    );

    // mem_ack only counts while a transaction is outstanding
    assign w_ack_i = (r_state == BUSY_I) && bus.mem_ack;
    assign w_ack_d = (r_state == BUSY_D) && bus.mem_ack;

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        case (r_state)
            IDLE: begin
                if (w_gnt == GNT_D) begin
                    w_state_nxt = BUSY_D;
                end else if (w_gnt == GNT_I) begin
                    w_state_nxt = BUSY_I;
                end
                if (!bus.if_req || (w_gnt == GNT_I)) begin
                    w_starve_nxt = '0;
                end else if ((w_gnt == GNT_D) && (r_starve_cnt < LIMIT)) begin
                    w_starve_nxt = r_starve_cnt + CNT_W'(1);
                end
            end
            BUSY_I: if (w_ack_i) w_state_nxt = IDLE;
            BUSY_D: if (w_ack_d) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
        end else begin
            r_if_ready <= w_ack_i;
            r_d_ready  <= w_ack_d;
            if (r_state == IDLE) begin
                case (w_gnt)
                    GNT_D: begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.d_we;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                    end
                    GNT_I: begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= bus.if_addr;
                        r_mem_wdata <= '0;
                    end
                    default: ;
                endcase
            end
            if (w_ack_i || w_ack_d) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
            end
            if (w_ack_i) begin
                r_if_rdata <= bus.mem_rdata;
            end
            // a store leaves the last load data visible
            if (w_ack_d && !r_mem_we) begin
                r_d_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.d_ready   = r_d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Memory model: ack arrives mem_lat cycles after mem_req rises; tolerates mem_req dropping early
    logic [31:0] marr [0:63];
    int          mem_lat  = 1;
    int          mcnt     = 0;
    logic        ack_r    = 1'b0;
    logic        pre_done = 1'b0;

    always @(posedge clk) begin
        if (!pre_done) begin
            for (int k = 0; k < 64; k++) marr[k] = 32'h0;
            marr[4]  = 32'h0051_0093;
            marr[8]  = 32'hCAFE_0001;
            pre_done = 1'b1;
        end
        if (!bus.mem_req || ack_r) begin
            mcnt  <= 0;
            ack_r <= 1'b0;
        end else begin
            mcnt <= mcnt + 1;
            if (mcnt + 1 == mem_lat) ack_r <= 1'b1;
        end
        if (ack_r && bus.mem_req && bus.mem_we) marr[bus.mem_addr[7:2]] = bus.mem_wdata;
    end

    assign bus.mem_ack   = ack_r;
    assign bus.mem_rdata = marr[bus.mem_addr[7:2]];

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_cyc;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // One complete transaction; cycle 0 is the cycle the request is first presented
    task automatic run_xact(input logic is_d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat,
                            output int rcyc, output logic [31:0] g_we, output logic [31:0] g_addr,
                            output logic [31:0] g_wdata, output logic [31:0] rdata, output int npulse);
        logic rdy;
        mem_lat = lat;
        rcyc    = -1;
        npulse  = 0;
        g_we    = 32'hFFFF_FFFF;
        g_addr  = 32'hFFFF_FFFF;
        g_wdata = 32'hFFFF_FFFF;
        rdata   = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                g_we    = 32'(bus.mem_we);
                g_addr  = bus.mem_addr;
                g_wdata = bus.mem_wdata;
            end
            rdy = is_d ? bus.d_ready : bus.if_ready;
            if (rdy) begin
                if (rcyc < 0) rcyc = c;
                npulse++;
                rdata = is_d ? bus.d_rdata : bus.if_rdata;
                bus.d_req  = 1'b0;
                bus.if_req = 1'b0;
            end
            if (rcyc >= 0 && c > rcyc + 3) break;
        end
    endtask

    initial begin
        int          rc, np, ng, req_cyc, unstable, ackc, rises;
        logic [31:0] gwe, gaddr, gwd, rd;
        logic [31:0] ref_addr, ref_wd;
        logic        ref_we, prev;
        int          gexp [10];
        int          cexp [10];

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        vecs[0] = '{is_d:1'b0, we:1'b0, addr:32'h10, wdata:32'h0,         lat:1, exp_cyc:3, exp_rdata:32'h0051_0093};
        vecs[1] = '{is_d:1'b1, we:1'b1, addr:32'h64, wdata:32'hDEAD_BEEF, lat:1, exp_cyc:3, exp_rdata:32'h0};
        vecs[2] = '{is_d:1'b1, we:1'b0, addr:32'h64, wdata:32'h0,         lat:1, exp_cyc:3, exp_rdata:32'hDEAD_BEEF};
        vecs[3] = '{is_d:1'b1, we:1'b1, addr:32'h64, wdata:32'h1234_5678, lat:2, exp_cyc:4, exp_rdata:32'hDEAD_BEEF};
        vecs[4] = '{is_d:1'b1, we:1'b0, addr:32'h64, wdata:32'h0,         lat:3, exp_cyc:5, exp_rdata:32'h1234_5678};
        vecs[5] = '{is_d:1'b0, we:1'b0, addr:32'h20, wdata:32'h0,         lat:5, exp_cyc:7, exp_rdata:32'hCAFE_0001};

        gexp = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        cexp = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state",     32'(dut.r_state), 32'h0);
        chk("rst_starve",    32'(dut.r_starve_cnt), 32'h0);
        chk("rst_mem_req",   32'(bus.mem_req), 32'h0);
        chk("rst_mem_we",    32'(bus.mem_we), 32'h0);
        chk("rst_if_ready",  32'(bus.if_ready), 32'h0);
        chk("rst_d_ready",   32'(bus.d_ready), 32'h0);
        chk("rst_mem_addr",  bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_if_rdata",  bus.if_rdata, 32'h0);
        chk("rst_d_rdata",   bus.d_rdata, 32'h0);
        reset = 1'b0;

        // Table of single transactions
        for (int i = 0; i < 6; i++) begin
            run_xact(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
                     rc, gwe, gaddr, gwd, rd, np);
            chk($sformatf("v%0d_ready_cycle", i), 32'(rc), 32'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_pulses", i), 32'(np), 32'd1);
            chk($sformatf("v%0d_mem_we", i), gwe, vecs[i].is_d ? 32'(vecs[i].we) : 32'h0);
            chk($sformatf("v%0d_mem_addr", i), gaddr, vecs[i].addr);
            chk($sformatf("v%0d_mem_wdata", i), gwd, vecs[i].is_d ? vecs[i].wdata : 32'h0);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            if (i == 4) chk("if_rdata_held_over_data", bus.if_rdata, 32'h0051_0093);
        end
        chk("d_rdata_held_over_fetch", bus.d_rdata, 32'h1234_5678);

        // Contention: both requesters held high, starvation limit 4
        mem_lat = 1;
        @(posedge clk); #1;
        bus.if_addr = 32'h100; bus.d_addr = 32'h200; bus.d_we = 1'b0; bus.d_wdata = 32'h0;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        ng = 0; prev = 1'b0;
        for (int c = 0; c < 100 && ng < 10; c++) begin
            @(negedge clk);
            if (bus.mem_req && !prev) begin
                chk($sformatf("grant%0d_is_data", ng), 32'(bus.mem_addr == 32'h200), 32'(gexp[ng]));
                chk($sformatf("grant%0d_starve_cnt", ng), 32'(dut.r_starve_cnt), 32'(cexp[ng]));
                ng++;
            end
            prev = bus.mem_req;
        end
        chk("contention_grant_count", 32'(ng), 32'd10);
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (8) @(negedge clk);

        // Variable latency: 5-cycle ack, inputs changed after grant must be ignored
        mem_lat = 5;
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h64; bus.d_wdata = 32'h0;
        rc = -1; np = 0; req_cyc = 0; unstable = 0; ackc = -1;
        ref_we = 1'b0; ref_addr = '0; ref_wd = '0; rd = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 1) begin
                ref_we = bus.mem_we; ref_addr = bus.mem_addr; ref_wd = bus.mem_wdata;
                bus.d_addr = 32'h80; bus.d_wdata = 32'hFFFF_0000; bus.d_we = 1'b1;
            end
            if (bus.mem_req) begin
                req_cyc++;
                if (bus.mem_we !== ref_we || bus.mem_addr !== ref_addr || bus.mem_wdata !== ref_wd)
                    unstable++;
            end
            if (bus.mem_ack && ackc < 0) ackc = c;
            if (bus.d_ready) begin
                if (rc < 0) rc = c;
                np++;
                rd = bus.d_rdata;
                bus.d_req = 1'b0;
            end
        end
        chk("lat5_unstable_cycles", 32'(unstable), 32'd0);
        chk("lat5_mem_addr", ref_addr, 32'h64);
        chk("lat5_mem_req_cycles", 32'(req_cyc), 32'd6);
        chk("lat5_ready_cycle", 32'(rc), 32'd7);
        chk("lat5_ready_after_ack", 32'(rc), 32'(ackc + 1));
        chk("lat5_pulses", 32'(np), 32'd1);
        chk("lat5_rdata", rd, 32'h1234_5678);

        // Reset while a store is outstanding
        mem_lat = 5;
        @(posedge clk); #1;
        bus.if_addr = 32'h100; bus.if_req = 1'b1;
        bus.d_addr = 32'h40; bus.d_wdata = 32'hAAAA_5555; bus.d_we = 1'b1; bus.d_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_pre_state", 32'(dut.r_state), 32'(BUSY_D));
        chk("midrst_pre_starve", 32'(dut.r_starve_cnt), 32'd1);
        @(negedge clk);
        reset = 1'b1; bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);
        chk("midrst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("midrst_state", 32'(dut.r_state), 32'(IDLE));
        chk("midrst_starve", 32'(dut.r_starve_cnt), 32'h0);
        chk("midrst_d_ready", 32'(bus.d_ready), 32'h0);
        chk("midrst_mem_addr", bus.mem_addr, 32'h0);
        chk("midrst_d_rdata", bus.d_rdata, 32'h0);
        reset = 1'b0;
        np = 0; rises = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.d_ready) np++;
            if (bus.mem_req) rises++;
        end
        chk("midrst_no_ready", 32'(np), 32'd0);
        chk("midrst_no_req", 32'(rises), 32'd0);
        chk("midrst_store_abandoned", marr[16], 32'h0);

        // Request dropped one cycle after grant
        mem_lat = 2;
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h64; bus.d_wdata = 32'h0;
        np = 0; rises = 0; prev = 1'b0; rd = '0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c == 1) bus.d_req = 1'b0;
            if (bus.mem_req && !prev) rises++;
            prev = bus.mem_req;
            if (bus.d_ready) begin
                np++;
                rd = bus.d_rdata;
            end
        end
        chk("drop_grants", 32'(rises), 32'd1);
        chk("drop_pulses", 32'(np), 32'd1);
        chk("drop_rdata", rd, 32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
